// File: rtl/cnn_acc_pkg.sv
// Constants shared by the CNN accelerator BRAM fill and PE-read sides.
// Loader FSM encodings, BRAM target selects and the default geometry.
package cnn_acc_pkg;

  localparam int unsigned CNN_DW = 16;
  localparam int unsigned CNN_AW = 10;

  localparam logic [1:0] LDR_IDLE = 2'd0;
  localparam logic [1:0] LDR_LOAD = 2'd1;
  localparam logic [1:0] LDR_DONE = 2'd2;

  localparam logic SEL_BRAM_A = 1'b0;
  localparam logic SEL_BRAM_B = 1'b1;

endpackage

// File: rtl/bram_loader.sv
// Stream-to-BRAM writer: fills feature-map BRAM A or weight BRAM B from a valid/ready stream.
// Optional running checksum output enabled by BRAM_LOADER_CHECKSUM_EN.
module bram_loader
  import cnn_acc_pkg::*;
#(
  parameter int unsigned DW = CNN_DW,
  parameter int unsigned AW = CNN_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          sel,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   count,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          wea,
  output logic [AW-1:0] addra,
  output logic [DW-1:0] dina,
  output logic          web,
  output logic [AW-1:0] addrb,
  output logic [DW-1:0] dinb,
  output logic          busy,
  output logic          done
`ifdef BRAM_LOADER_CHECKSUM_EN
  ,
  output logic [DW-1:0] checksum
`endif
);

  logic [1:0]    state;
  logic          sel_q;
  logic [AW-1:0] base_q;
  logic [AW:0]   count_q;
  logic [AW:0]   idx;
  logic [AW:0]   idx_nxt;
  logic [AW-1:0] waddr;
  logic          hs;

  assign s_ready = (state == LDR_LOAD);
  assign busy    = (state != LDR_IDLE);
  assign done    = (state == LDR_DONE);
  assign hs      = s_valid & s_ready;
  assign idx_nxt = idx + {{AW{1'b0}}, 1'b1};
  // Truncating to AW bits gives the modulo-depth wrap of the write address.
  assign waddr   = base_q + idx[AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LDR_IDLE;
      sel_q   <= SEL_BRAM_A;
      base_q  <= '0;
      count_q <= '0;
      idx     <= '0;
      wea     <= 1'b0;
      addra   <= '0;
      dina    <= '0;
      web     <= 1'b0;
      addrb   <= '0;
      dinb    <= '0;
    end else begin
      // Write strobes last one cycle; idle ports present zero address/data.
      wea   <= 1'b0;
      addra <= '0;
      dina  <= '0;
      web   <= 1'b0;
      addrb <= '0;
      dinb  <= '0;
      case (state)
        LDR_IDLE: begin
          if (start) begin
            sel_q   <= sel;
            base_q  <= base;
            count_q <= count;
            idx     <= '0;
            state   <= (count == '0) ? LDR_DONE : LDR_LOAD;
          end
        end
        LDR_LOAD: begin
          if (hs) begin
            if (sel_q == SEL_BRAM_A) begin
              wea   <= 1'b1;
              addra <= waddr;
              dina  <= s_data;
            end else begin
              web   <= 1'b1;
              addrb <= waddr;
              dinb  <= s_data;
            end
            idx <= idx_nxt;
            if (idx_nxt == count_q) state <= LDR_DONE;
          end
        end
        LDR_DONE: state <= LDR_IDLE;
        default:  state <= LDR_IDLE;
      endcase
    end
  end

`ifdef BRAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= '0;
    end else if (state == LDR_IDLE && start) begin
      checksum <= '0;
    end else if (hs) begin
      checksum <= checksum + s_data;
    end
  end
`endif

endmodule

// File: tb/tb_bram_loader.sv
// Self-checking bench for bram_loader: per-cycle vector table plus a full-depth fill sequence.
// Checksum expectations are compared only when BRAM_LOADER_CHECKSUM_EN is defined.
module tb_bram_loader;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          sel;
  logic [AW-1:0] base;
  logic [AW:0]   count;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic          web;
  logic [AW-1:0] addrb;
  logic [DW-1:0] dinb;
  logic          busy;
  logic          done;
`ifdef BRAM_LOADER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  always #5 clk = ~clk;

  bram_loader #(.DW(DW), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sel     (sel),
    .base    (base),
    .count   (count),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .wea     (wea),
    .addra   (addra),
    .dina    (dina),
    .web     (web),
    .addrb   (addrb),
    .dinb    (dinb),
    .busy    (busy),
`ifdef BRAM_LOADER_CHECKSUM_EN
    .done    (done),
    .checksum(checksum)
`else
    .done    (done)
`endif
  );

  typedef struct {
    logic          rst;
    logic          start;
    logic          sel;
    logic [AW-1:0] base;
    logic [AW:0]   count;
    logic          valid;
    logic [DW-1:0] data;
    logic          e_ready;
    logic          e_busy;
    logic          e_done;
    logic          e_wea;
    logic [AW-1:0] e_addra;
    logic [DW-1:0] e_dina;
    logic          e_web;
    logic [AW-1:0] e_addrb;
    logic [DW-1:0] e_dinb;
    logic          ck_chk;
    logic [DW-1:0] e_ck;
  } vec_t;

  vec_t tbl[$];
  int   total  = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got %h exp %h", name, got, exp);
  endtask

  task automatic v(input logic r, input logic st, input logic sl, input logic [AW-1:0] b,
                   input logic [AW:0] c, input logic vl, input logic [DW-1:0] d,
                   input logic er, input logic eb, input logic ed,
                   input logic ewa, input logic [AW-1:0] eaa, input logic [DW-1:0] eda,
                   input logic ewb, input logic [AW-1:0] eab, input logic [DW-1:0] edb,
                   input logic cc, input logic [DW-1:0] eck);
    tbl.push_back('{r, st, sl, b, c, vl, d, er, eb, ed, ewa, eaa, eda, ewb, eab, edb, cc, eck});
  endtask

  function automatic logic [63:0] pack_out();
    return {7'd0, s_ready, busy, done, wea, addra, dina, web, addrb, dinb};
  endfunction

  int          nw;
  int          sent;
  int          cyc;
  bit          seen_done;
  logic [63:0] exp_o;

  initial begin
    rst = 1'b1; start = 1'b0; sel = 1'b0; base = '0; count = '0;
    s_valid = 1'b0; s_data = '0;

    // reset held three cycles, then the cycle after it falls
    v(1,0,0,0,0,0,0,       0,0,0, 0,0,0, 0,0,0, 0,0);
    v(1,0,0,0,0,0,0,       0,0,0, 0,0,0, 0,0,0, 0,0);
    v(1,0,0,0,0,0,0,       0,0,0, 0,0,0, 0,0,0, 1,0);
    v(0,0,0,0,0,0,0,       0,0,0, 0,0,0, 0,0,0, 1,0);
    // basic A load, start during DONE ignored
    v(0,1,0,0,4,0,0,       0,0,0, 0,0,0, 0,0,0, 0,0);
    v(0,0,0,0,0,1,16'h0011, 1,1,0, 0,0,0, 0,0,0, 0,0);
    v(0,0,0,0,0,1,16'h0022, 1,1,0, 1,10'h000,16'h0011, 0,0,0, 0,0);
    v(0,0,0,0,0,1,16'h0033, 1,1,0, 1,10'h001,16'h0022, 0,0,0, 0,0);
    v(0,0,0,0,0,1,16'h0044, 1,1,0, 1,10'h002,16'h0033, 0,0,0, 0,0);
    v(0,1,1,3,2,1,16'h0055, 0,1,1, 1,10'h003,16'h0044, 0,0,0, 1,16'h00AA);
    v(0,0,0,0,0,0,0,       0,0,0, 0,0,0, 0,0,0, 1,16'h00AA);
    v(0,0,0,0,0,0,0,       0,0,0, 0,0,0, 0,0,0, 0,0);
    // wrap on B
    v(0,1,1,10'h3FE,4,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0);
    v(0,0,0,0,0,1,16'h0001, 1,1,0, 0,0,0, 0,0,0, 0,0);
    v(0,0,0,0,0,1,16'h0002, 1,1,0, 0,0,0, 1,10'h3FE,16'h0001, 0,0);
    v(0,0,0,0,0,1,16'h0003, 1,1,0, 0,0,0, 1,10'h3FF,16'h0002, 0,0);
    v(0,0,0,0,0,1,16'h0004, 1,1,0, 0,0,0, 1,10'h000,16'h0003, 0,0);
    v(0,0,0,0,0,0,0,       0,1,1, 0,0,0, 1,10'h001,16'h0004, 1,16'h000A);
    v(0,0,0,0,0,0,0,       0,0,0, 0,0,0, 0,0,0, 0,0);
    // stalls: valid pattern 1,0,0,1,0,1
    v(0,1,1,10'h010,3,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0);
    v(0,0,0,0,0,1,16'h00A1, 1,1,0, 0,0,0, 0,0,0, 0,0);
    v(0,0,0,0,0,0,0,       1,1,0, 0,0,0, 1,10'h010,16'h00A1, 0,0);
    v(0,0,0,0,0,0,0,       1,1,0, 0,0,0, 0,0,0, 0,0);
    v(0,0,0,0,0,1,16'h00A2, 1,1,0, 0,0,0, 0,0,0, 0,0);
    v(0,0,0,0,0,0,0,       1,1,0, 0,0,0, 1,10'h011,16'h00A2, 0,0);
    v(0,0,0,0,0,1,16'h00A3, 1,1,0, 0,0,0, 0,0,0, 0,0);
    v(0,0,0,0,0,0,0,       0,1,1, 0,0,0, 1,10'h012,16'h00A3, 1,16'h01E6);
    v(0,0,0,0,0,0,0,       0,0,0, 0,0,0, 0,0,0, 0,0);
    // start during LOAD ignored, then zero count
    v(0,1,0,10'h100,3,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0);
    v(0,1,1,0,1,1,16'h0001, 1,1,0, 0,0,0, 0,0,0, 0,0);
    v(0,1,1,0,1,1,16'h0002, 1,1,0, 1,10'h100,16'h0001, 0,0,0, 0,0);
    v(0,0,0,0,0,1,16'h0003, 1,1,0, 1,10'h101,16'h0002, 0,0,0, 0,0);
    v(0,0,0,0,0,0,0,       0,1,1, 1,10'h102,16'h0003, 0,0,0, 1,16'h0006);
    v(0,1,1,10'h055,0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,16'h0006);
    v(0,0,0,0,0,1,16'hBEEF, 0,1,1, 0,0,0, 0,0,0, 1,16'h0000);
    v(0,0,0,0,0,0,0,       0,0,0, 0,0,0, 0,0,0, 1,16'h0000);
    // reset after 2 of 8 words, then a fresh 2-word command on B
    v(0,1,0,10'h020,8,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0);
    v(0,0,0,0,0,1,16'h0101, 1,1,0, 0,0,0, 0,0,0, 0,0);
    v(0,0,0,0,0,1,16'h0102, 1,1,0, 1,10'h020,16'h0101, 0,0,0, 0,0);
    v(1,0,0,0,0,1,16'h0103, 1,1,0, 1,10'h021,16'h0102, 0,0,0, 0,0);
    v(0,0,0,0,0,0,0,       0,0,0, 0,0,0, 0,0,0, 1,16'h0000);
    v(0,1,1,10'h2A0,2,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0);
    v(0,0,0,0,0,1,16'h0201, 1,1,0, 0,0,0, 0,0,0, 0,0);
    v(0,0,0,0,0,1,16'h0202, 1,1,0, 0,0,0, 1,10'h2A0,16'h0201, 0,0);
    v(0,0,0,0,0,0,0,       0,1,1, 0,0,0, 1,10'h2A1,16'h0202, 1,16'h0403);
    v(0,0,0,0,0,0,0,       0,0,0, 0,0,0, 0,0,0, 0,0);

    // Inputs are driven just after the edge; outputs are compared once they have settled.
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      rst = tbl[i].rst; start = tbl[i].start; sel = tbl[i].sel; base = tbl[i].base;
      count = tbl[i].count; s_valid = tbl[i].valid; s_data = tbl[i].data;
      #1;
      exp_o = {7'd0, tbl[i].e_ready, tbl[i].e_busy, tbl[i].e_done,
               tbl[i].e_wea, tbl[i].e_addra, tbl[i].e_dina,
               tbl[i].e_web, tbl[i].e_addrb, tbl[i].e_dinb};
      check($sformatf("vec%0d", i), pack_out(), exp_o);
`ifdef BRAM_LOADER_CHECKSUM_EN
      if (tbl[i].ck_chk) check($sformatf("ck%0d", i), {48'd0, checksum}, {48'd0, tbl[i].e_ck});
`endif
    end

    // full-depth fill on A from base 5: count = 2^AW wraps once through every address
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b1; sel = 1'b0; base = 10'h005; count = 11'd1024;
    s_valid = 1'b0; s_data = '0;
    nw = 0; sent = 0; seen_done = 1'b0; cyc = 0;
    while (!seen_done && cyc < 1100) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (web) check("fill_web", {63'd0, web}, 64'd0);
      if (wea) begin
        check($sformatf("fill_w%0d", nw), {38'd0, addra, dina},
              {38'd0, 10'((nw + 5) % 1024), 16'(nw)});
        nw++;
      end
      if (done) begin
        seen_done = 1'b1;
        check("fill_done_with_last_write", {63'd0, wea}, 64'd1);
        check("fill_nwrites", 64'(nw), 64'd1024);
`ifdef BRAM_LOADER_CHECKSUM_EN
        check("fill_ck", {48'd0, checksum}, 64'h0000_0000_0000_FE00);
`endif
        s_valid = 1'b0;
      end else if (s_ready) begin
        s_valid = 1'b1;
        s_data  = 16'(sent);
        sent++;
      end else begin
        s_valid = 1'b0;
      end
    end
    if (!seen_done) check("fill_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    check("fill_idle_after", {61'd0, busy, s_ready, wea}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
